// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency backing memory between the I-cache and D-cache miss paths
// Ports: clk, rst (async active-low); i_req/i_addr -> i_grant/i_done/i_rdata (instruction reads);
//        d_req/d_wr/d_addr/d_wdata -> d_grant/d_done/d_rdata (data reads/writes);
//        mem_addr/mem_wdata/mem_rd/mem_wr/mem_stall/mem_rdata (memory side); busy; err (sticky).
// Optional: define ARB_RR_EN to alternate the winner on simultaneous requests (default: D over I).
module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_grant,
  output logic        i_done,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_grant,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_stall,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  state_t state, state_nx;
  logic owner_d, wr_q, take_d, owner_req, accept;
  logic [3:0] cnt;
  logic [15:0] sel_addr;
`ifdef ARB_RR_EN
  logic last_d;
  // On a tie the side not served last wins; last_d resets to "I served last".
  always_comb take_d = d_req & (~i_req | ~last_d);
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_d <= 1'b0;
    else if (accept) last_d <= take_d;
`else
  always_comb take_d = d_req;
`endif
  always_comb begin
    accept = (state == IDLE) & (d_req | i_req);
    sel_addr = take_d ? d_addr : i_addr;
    owner_req = owner_d ? d_req : i_req;
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? ISSUE : IDLE;
      ISSUE:   state_nx = mem_stall ? ISSUE : WAIT;
      WAIT:    state_nx = (cnt == 4'd0) ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
    busy = state != IDLE;
    mem_rd = (state == ISSUE) & ~wr_q;
    mem_wr = (state == ISSUE) & wr_q;
    i_grant = busy & ~owner_d;
    d_grant = busy & owner_d;
    i_done = (state == RESP) & ~owner_d;
    d_done = (state == RESP) & owner_d;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_d <= 1'b0;
      wr_q <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cnt <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      err <= 1'b0;
    end else begin
      if (accept) begin
        owner_d <= take_d;
        wr_q <= take_d & d_wr;
        mem_addr <= {sel_addr[15:1], 1'b0};
        mem_wdata <= take_d ? d_wdata : '0;
        if (sel_addr[0]) err <= 1'b1;
      end
      // The owner must hold its request until its done pulse.
      if ((state == ISSUE || state == WAIT) && !owner_req) err <= 1'b1;
      if (state == ISSUE) cnt <= LAT_M1;
      if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == WAIT && cnt == 4'd0) begin
        if (owner_d) d_rdata <= wr_q ? '0 : mem_rdata;
        else i_rdata <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus plus a cycle-timed transaction model checking mem_arbiter every cycle
module tb_mem_arbiter;
  localparam int LAT = 4;
  logic clk, rst;
  logic i_req, i_grant, i_done, d_req, d_wr, d_grant, d_done;
  logic mem_rd, mem_wr, mem_stall, busy, err;
  logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  int checks = 0;
  int failures = 0;
  string ord;

  mem_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string n, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  task automatic cmp1(input string n, input logic got, input logic exp);
    cmp(n, {15'b0, got}, {15'b0, exp});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_req = 0; d_req = 0; d_wr = 0; mem_stall = 0;
    rst = 0;
    step(2);
    rst = 1;
    step(1);
  endtask

  // Transaction model: a granted access strobes from the cycle after grant until the first
  // cycle memory is not stalled (cycle e); data is taken at e+LAT and done shows at e+LAT+1.
  int mc = 0;
  int m_e = 0;
  bit m_act, m_ek, m_od, m_wr, m_err, m_dn, pick_d;
  logic [15:0] m_addr, m_wdata, m_ir, m_dr, sel;
`ifdef ARB_RR_EN
  bit m_last_d;
`endif
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      cmp("rst_flags", {8'b0, busy, err, i_grant, d_grant, i_done, d_done, mem_rd, mem_wr}, 16'h0);
      cmp("rst_mem_addr", mem_addr, 16'h0);
      cmp("rst_mem_wdata", mem_wdata, 16'h0);
      cmp("rst_i_rdata", i_rdata, 16'h0);
      cmp("rst_d_rdata", d_rdata, 16'h0);
      m_act = 0; m_ek = 0; m_err = 0; m_addr = 0; m_wdata = 0; m_ir = 0; m_dr = 0;
`ifdef ARB_RR_EN
      m_last_d = 0;
`endif
    end else begin
      m_dn = m_act && m_ek && (mc == m_e + LAT + 1);
      cmp1("busy", busy, m_act);
      cmp1("mem_rd", mem_rd, m_act && !m_ek && !m_wr);
      cmp1("mem_wr", mem_wr, m_act && !m_ek && m_wr);
      cmp1("i_grant", i_grant, m_act && !m_od);
      cmp1("d_grant", d_grant, m_act && m_od);
      cmp1("i_done", i_done, m_dn && !m_od);
      cmp1("d_done", d_done, m_dn && m_od);
      cmp1("err", err, m_err);
      cmp("mem_addr", mem_addr, m_addr);
      cmp("mem_wdata", mem_wdata, m_wdata);
      cmp("i_rdata", i_rdata, m_ir);
      cmp("d_rdata", d_rdata, m_dr);
      if (m_act && !m_ek && !mem_stall) begin
        m_ek = 1;
        m_e = mc;
      end
      if (m_act && m_ek && mc == m_e + LAT) begin
        if (m_od) m_dr = m_wr ? 16'h0 : mem_rdata;
        else m_ir = mem_rdata;
      end
      if (m_act && !m_dn && !(m_od ? d_req : i_req)) m_err = 1;
      if (m_dn) m_act = 0;
      else if (!m_act && (d_req || i_req)) begin
`ifdef ARB_RR_EN
        pick_d = d_req && (!i_req || !m_last_d);
        m_last_d = pick_d;
`else
        pick_d = d_req;
`endif
        m_act = 1;
        m_ek = 0;
        m_od = pick_d;
        m_wr = pick_d && d_wr;
        sel = pick_d ? d_addr : i_addr;
        m_addr = sel & 16'hFFFE;
        m_wdata = pick_d ? d_wdata : 16'h0;
        if (sel[0]) m_err = 1;
      end
    end
    mc++;
  end

  task automatic tie_run(input int ntx, input bit again, output string o);
    int got = 0;
    int budget = 0;
    o = "";
    d_wr = 0; d_addr = 16'h0200; i_addr = 16'h0100; d_req = 1; i_req = 1;
    while (got < ntx && budget < 100) begin
      step(1);
      budget++;
      mem_rdata = 16'(budget * 3 + 7);
      if (d_done) begin o = {o, "D"}; got++; end
      if (i_done) begin o = {o, "I"}; got++; end
      d_req = d_done ? 1'b0 : (d_req | again);
      i_req = i_done ? 1'b0 : (i_req | again);
    end
    d_req = 0; i_req = 0;
    step(2);
  endtask

  task automatic cmps(input string n, input string got, input string exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%s exp=%s", n, got, exp);
    end
  endtask

  initial begin
    rst = 0; i_req = 0; d_req = 0; d_wr = 0; mem_stall = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    step(2);
    cmp1("lit_rst_busy", busy, 1'b0);
    cmp1("lit_rst_err", err, 1'b0);
    rst = 1;
    step(1);
    // I read
    i_req = 1; i_addr = 16'h0040; mem_rdata = 16'h0BAD;
    step(1);
    cmp1("lit_i_rd_c1", mem_rd, 1'b1);
    cmp("lit_i_addr_c1", mem_addr, 16'h0040);
    step(4);
    mem_rdata = 16'hBEEF;
    step(1);
    cmp1("lit_i_done_c6", i_done, 1'b1);
    cmp("lit_i_rdata_c6", i_rdata, 16'hBEEF);
    cmp1("lit_d_done_c6", d_done, 1'b0);
    i_req = 0; mem_rdata = 16'h0BAD;
    step(1);
    cmp1("lit_idle_c7", busy, 1'b0);
    // D write with two stalled strobe cycles
    d_req = 1; d_wr = 1; d_addr = 16'h1002; d_wdata = 16'h1234; mem_stall = 1; mem_rdata = 16'hFFFF;
    step(1);
    cmp1("lit_wr_c1", mem_wr, 1'b1);
    step(2);
    mem_stall = 0;
    cmp1("lit_wr_c3", mem_wr, 1'b1);
    cmp("lit_wdata_c3", mem_wdata, 16'h1234);
    step(1);
    cmp1("lit_wr_c4", mem_wr, 1'b0);
    step(4);
    cmp1("lit_d_done_c8", d_done, 1'b1);
    cmp("lit_d_rdata_c8", d_rdata, 16'h0000);
    d_req = 0; d_wr = 0;
    step(1);
    // Tie: D first, then the waiting I side
    do_reset();
    tie_run(2, 1'b0, ord);
    cmps("tie_order", ord, "DI");
`ifdef ARB_RR_EN
    do_reset();
    tie_run(4, 1'b1, ord);
    cmps("rr_order", ord, "DIDI");
`endif
    // Misaligned address
    do_reset();
    d_req = 1; d_wr = 0; d_addr = 16'h0003; mem_rdata = 16'h7777;
    step(1);
    cmp("lit_misalign_addr", mem_addr, 16'h0002);
    cmp1("lit_misalign_err", err, 1'b1);
    step(5);
    cmp1("lit_misalign_done", d_done, 1'b1);
    d_req = 0;
    step(1);
    // Request dropped during WAIT
    do_reset();
    i_req = 1; i_addr = 16'h0010;
    step(3);
    i_req = 0;
    step(1);
    cmp1("lit_drop_err_c4", err, 1'b1);
    step(3);
    cmp1("lit_drop_err_c7", err, 1'b1);
    rst = 0;
    #1;
    cmp1("lit_drop_err_rst", err, 1'b0);
    step(1);
    rst = 1;
    step(1);
    // Reset in the middle of a transaction
    d_req = 1; d_wr = 0; d_addr = 16'h0300; mem_rdata = 16'h5A5A;
    step(3);
    rst = 0;
    #1;
    cmp1("lit_abort_busy", busy, 1'b0);
    cmp1("lit_abort_grant", d_grant, 1'b0);
    cmp("lit_abort_addr", mem_addr, 16'h0000);
    d_req = 0;
    step(1);
    rst = 1;
    step(5);
    cmp1("lit_abort_nodone", d_done, 1'b0);
    d_req = 1; d_addr = 16'h0302;
    step(6);
    cmp1("lit_fresh_done", d_done, 1'b1);
    cmp("lit_fresh_rdata", d_rdata, 16'h5A5A);
    d_req = 0;
    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared backing memory between the instruction-cache miss path and the data-cache miss/writeback path.
- Sits between the two cache controllers (fetch side, memory side) and the four-cycle banked main memory.
- Accepts one request at a time, issues a single memory access, counts the fixed memory latency, then returns data with a one-cycle done pulse.
- Data side has priority by default, so a memory-stage miss is never blocked behind a fetch miss.

Parameters:
- LATENCY, 4, cycles from the memory rd/wr pulse to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  instruction-side read request, level
- i_addr  in  16  instruction-side byte address
- i_grant  out  1  instruction side owns memory (ISSUE through RESP)
- i_done  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  16  read data for instruction side
- d_req  in  1  data-side request, level
- d_wr  in  1  1 = write, 0 = read; sampled with d_req
- d_addr  in  16  data-side byte address
- d_wdata  in  16  data-side write data
- d_grant  out  1  data side owns memory
- d_done  out  1  one-cycle pulse, d_rdata valid
- d_rdata  out  16  read data for data side
- mem_addr  out  16  memory address, registered
- mem_wdata  out  16  memory write data, registered
- mem_rd  out  1  memory read strobe, one cycle per accepted issue
- mem_wr  out  1  memory write strobe, one cycle per accepted issue
- mem_stall  in  1  memory cannot accept a strobe this cycle
- mem_rdata  in  16  memory read data, valid LATENCY cycles after the strobe
- busy  out  1  state != IDLE
- err  out  1  sticky protocol error

Behaviour:
- Reset: state IDLE. All outputs 0, including mem_addr, mem_wdata, rdata registers and err. Counter 0. Reset asserted mid-transaction aborts it with no done pulse.
- IDLE:
  - Requests are sampled only in this state.
  - If d_req: grant D. Else if i_req: grant I.
  - On grant, latch owner, addr with bit 0 forced 0, wr (I side always 0) and wdata into registers; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - Drive mem_rd or mem_wr high for the latched op.
  - If mem_stall is high, stay in ISSUE and hold the strobe.
  - Else load the counter with LATENCY-1 and go to WAIT.
  - The strobe is high exactly in ISSUE cycles.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture mem_rdata (reads) or 0 (writes) into the owner's rdata register and go to RESP.
- RESP:
  - Owner's done is high for one cycle; rdata is held until the next capture.
  - Next state is IDLE.
- Timing, no stall: req high in cycle 0, strobe in cycle 1, WAIT in cycles 2..LATENCY+1, done in cycle LATENCY+2. LATENCY=4 gives done in cycle 6.
- Requester handshake: a requester must drop req in the cycle its done is high. A req still high in the following IDLE cycle is a new request.
- Grants: i_grant and d_grant are mutually exclusive, high from ISSUE through RESP.
- err (sticky until reset) is set when:
  - an accepted address has bit 0 = 1; the request is still served at the aligned address;
  - the owner's req is low in any ISSUE/WAIT cycle.
- Simultaneous requests in IDLE: D wins unless the optional feature is enabled. The loser keeps req high and is served next.
- LATENCY=1: WAIT lasts one cycle.

Optional Feature:
- Macro: ARB_RR_EN
- Defined: on a tie in IDLE, the winner is the side not served last. last_served resets to I, so the first tie goes to D, the second to I, alternating after that. Non-tie grants update last_served too.
- Undefined: fixed D-over-I priority, no last_served state.

Test Plan:
- I read, LATENCY=4: i_req=1, i_addr=0x0040, mem_rdata=0xBEEF in cycle 5 -> mem_rd cycle 1 with mem_addr=0x0040; i_done in cycle 6 with i_rdata=0xBEEF; d_done stays 0.
- D write under stall: d_req=1, d_wr=1, d_addr=0x1002, d_wdata=0x1234, mem_stall high for 2 cycles -> mem_wr high cycles 1-3, d_done in cycle 8, d_rdata=0, mem_wdata=0x1234.
- Tie, macro undefined: i_req and d_req both high continuously -> D served first, I served next. i_grant rises only after d_done; the two grants never overlap.
- Tie, ARB_RR_EN defined: both sides reissue immediately after their done, 4 transactions -> service order D, I, D, I.
- Errors: d_addr=0x0003 -> mem_addr=0x0002 and err=1 after acceptance. Separately, i_req dropped during WAIT -> err=1 and held until rst low.
- Reset: rst low in cycle 3 of a transaction -> busy=0 and all outputs 0 immediately. No done pulse after release, and a fresh request completes normally.
